// File: rtl/dft_readout_arbiter_if.sv
// Bundle of scan-chain readout, commit handshake and register-file write signals.
// The master drives the chain side; the slave is the arbiter.
interface dft_readout_arbiter_if #(
    parameter int p_sc_nbr = 16
) ();
    logic                    en;
    logic [32*p_sc_nbr-1:0]  dft_output_data;
    logic [p_sc_nbr-1:0]     dft_output_strobe;
    logic [p_sc_nbr-1:0]     dft_op_commit;
    logic [p_sc_nbr-1:0]     dft_commit_ack;
    logic [p_sc_nbr-1:0]     rf_wen;
    logic [31:0]             rf_wdata;
    logic [15:0]             wr_cnt;
    logic [p_sc_nbr-1:0]     ovf;
    logic                    ovf_clr;
    logic                    busy;

    modport master (
        output en, dft_output_data, dft_output_strobe, dft_op_commit, ovf_clr,
        input  dft_commit_ack, rf_wen, rf_wdata, wr_cnt, ovf, busy
    );

    modport slave (
        input  en, dft_output_data, dft_output_strobe, dft_op_commit, ovf_clr,
        output dft_commit_ack, rf_wen, rf_wdata, wr_cnt, ovf, busy
    );
endinterface

// File: rtl/dft_readout_arbiter.sv
// Round-robin readout of N one-word scan-chain buffers into a register file, 2-cycle strobe-to-write.
// A full buffer only refills while it is being granted; otherwise the word drops and ovf sticks.
module dft_readout_arbiter #(
    parameter int p_sc_nbr = 16
) (
    input logic                   clk,
    input logic                   reset,
    dft_readout_arbiter_if.slave  rb
);
    localparam int N  = p_sc_nbr;
    localparam int PW = $clog2(N);

    typedef enum logic [1:0] {ST_IDLE, ST_DRAIN, ST_ACK, ST_DONE} cst_e;

    logic [N-1:0]  pend_q, pend_d;
    logic [31:0]   buf_q [N];
    logic [31:0]   buf_d [N];
    logic [PW-1:0] ptr_q, ptr_d;
    logic [N-1:0]  ovf_q, ovf_d;
    logic [N-1:0]  rf_wen_q, rf_wen_d;
    logic [31:0]   rf_wdata_q, rf_wdata_d;
    logic [15:0]   wr_cnt_q, wr_cnt_d;
    cst_e          st_q [N];
    cst_e          st_d [N];

    logic          gnt_vld;
    logic [PW-1:0] gnt_idx;
    logic [PW:0]   scan;

    // First pending chain at or after ptr, walking cyclically.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        scan    = '0;
        if (rb.en) begin
            for (int k = 0; k < N; k++) begin
                scan = {1'b0, ptr_q} + (PW+1)'(k);
                if (scan >= (PW+1)'(N)) scan = scan - (PW+1)'(N);
                if (!gnt_vld && pend_q[scan[PW-1:0]]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = scan[PW-1:0];
                end
            end
        end
    end

    always_comb begin
        pend_d     = pend_q;
        ovf_d      = rb.ovf_clr ? '0 : ovf_q;
        ptr_d      = ptr_q;
        rf_wen_d   = '0;
        rf_wdata_d = rf_wdata_q;
        wr_cnt_d   = wr_cnt_q;
        for (int i = 0; i < N; i++) buf_d[i] = buf_q[i];

        if (gnt_vld) begin
            pend_d[gnt_idx]   = 1'b0;
            rf_wen_d[gnt_idx] = 1'b1;
            rf_wdata_d        = buf_q[gnt_idx];
            wr_cnt_d          = wr_cnt_q + 16'd1;
            ptr_d             = (gnt_idx == PW'(N-1)) ? '0 : gnt_idx + PW'(1);
        end

        // A strobe on the chain being granted refills the slot it just vacated.
        for (int i = 0; i < N; i++) begin
            if (rb.dft_output_strobe[i]) begin
                if (!pend_q[i] || (gnt_vld && gnt_idx == PW'(i))) begin
                    buf_d[i]  = rb.dft_output_data[32*i +: 32];
                    pend_d[i] = 1'b1;
                end else begin
                    ovf_d[i] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            st_d[i] = st_q[i];
            unique case (st_q[i])
                ST_IDLE:  if (rb.dft_op_commit[i]) st_d[i] = ST_DRAIN;
                ST_DRAIN: begin
                    if (!rb.dft_op_commit[i])
                        st_d[i] = ST_IDLE;
                    else if (!pend_q[i] && !rf_wen_q[i] && !rb.dft_output_strobe[i])
                        st_d[i] = ST_ACK;
                end
                ST_ACK:   st_d[i] = ST_DONE;
                ST_DONE:  if (!rb.dft_op_commit[i]) st_d[i] = ST_IDLE;
                default:  st_d[i] = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_q     <= '0;
            ptr_q      <= '0;
            ovf_q      <= '0;
            rf_wen_q   <= '0;
            rf_wdata_q <= '0;
            wr_cnt_q   <= '0;
            for (int i = 0; i < N; i++) begin
                buf_q[i] <= '0;
                st_q[i]  <= ST_IDLE;
            end
        end else begin
            pend_q     <= pend_d;
            ptr_q      <= ptr_d;
            ovf_q      <= ovf_d;
            rf_wen_q   <= rf_wen_d;
            rf_wdata_q <= rf_wdata_d;
            wr_cnt_q   <= wr_cnt_d;
            for (int i = 0; i < N; i++) begin
                buf_q[i] <= buf_d[i];
                st_q[i]  <= st_d[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) rb.dft_commit_ack[i] = (st_q[i] == ST_ACK);
    end

    assign rb.rf_wen   = rf_wen_q;
    assign rb.rf_wdata = rf_wdata_q;
    assign rb.wr_cnt   = wr_cnt_q;
    assign rb.ovf      = ovf_q;
    assign rb.busy     = (|pend_q) || (|rf_wen_q);
endmodule

// File: tb/tb_dft_readout_arbiter.sv
// Directed-vector bench for dft_readout_arbiter with 16 chains.
module tb_dft_readout_arbiter;
    logic clk;
    logic reset;
    int   n_vec;
    int   n_miss;

    dft_readout_arbiter_if #(.p_sc_nbr(16)) bus ();

    dft_readout_arbiter #(.p_sc_nbr(16)) dut (
        .clk   (clk),
        .reset (reset),
        .rb    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_reset;
        reset = 1'b0;
        tick;
        tick;
        reset = 1'b1;
        tick;
    endtask

    // One-cycle strobe on the chains in mask; chain i carries base|i.
    task automatic strobe(input logic [15:0] mask, input logic [31:0] base);
        for (int i = 0; i < 16; i++)
            if (mask[i]) bus.dft_output_data[32*i +: 32] = base | 32'(i);
        bus.dft_output_strobe = mask;
        tick;
        bus.dft_output_strobe = '0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (bus.busy && n < 20) begin
            tick;
            n++;
        end
        chk(tag, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        int wen_at, ack_at, ack_cnt, wen_cnt;
        n_vec  = 0;
        n_miss = 0;
        reset  = 1'b0;
        bus.en = 1'b0;
        bus.dft_output_data   = '0;
        bus.dft_output_strobe = '0;
        bus.dft_op_commit     = '0;
        bus.ovf_clr           = 1'b0;
        tick;

        chk("rst_wen",   32'(bus.rf_wen), 32'd0);
        chk("rst_wdata", bus.rf_wdata, 32'd0);
        chk("rst_cnt",   32'(bus.wr_cnt), 32'd0);
        chk("rst_ovf",   32'(bus.ovf), 32'd0);
        chk("rst_busy",  32'(bus.busy), 32'd0);
        chk("rst_ack",   32'(bus.dft_commit_ack), 32'd0);

        // Single word on chain 3.
        do_reset;
        bus.en = 1'b1;
        strobe(16'h0008, 32'hA5A5_0000);
        chk("s3_wen_t1",  32'(bus.rf_wen), 32'd0);
        chk("s3_busy_t1", 32'(bus.busy), 32'd1);
        tick;
        chk("s3_wen",   32'(bus.rf_wen), 32'h0008);
        chk("s3_wdata", bus.rf_wdata, 32'hA5A5_0003);
        chk("s3_cnt",   32'(bus.wr_cnt), 32'd1);
        tick;
        chk("s3_wen_off",  32'(bus.rf_wen), 32'd0);
        chk("s3_wdata_hold", bus.rf_wdata, 32'hA5A5_0003);
        chk("s3_busy_off", 32'(bus.busy), 32'd0);

        // All chains at once drain in index order.
        do_reset;
        bus.en = 1'b1;
        strobe(16'hFFFF, 32'hC0DE_0000);
        for (int k = 0; k < 16; k++) begin
            tick;
            chk("all_wen",   32'(bus.rf_wen), 32'd1 << k);
            chk("all_wdata", bus.rf_wdata, 32'hC0DE_0000 | 32'(k));
        end
        tick;
        chk("all_busy", 32'(bus.busy), 32'd0);
        chk("all_cnt",  32'(bus.wr_cnt), 32'd16);
        chk("all_ovf",  32'(bus.ovf), 32'd0);

        // Overflow on chain 5 while grants are disabled, plus ovf_clr behaviour.
        do_reset;
        bus.en = 1'b0;
        strobe(16'h0020, 32'h1111_0000);
        strobe(16'h0020, 32'h2222_0000);
        chk("ovf5_set",  32'(bus.ovf), 32'h0020);
        tick;
        chk("ovf5_nowen", 32'(bus.rf_wen), 32'd0);
        chk("ovf5_busy",  32'(bus.busy), 32'd1);
        bus.ovf_clr = 1'b1;
        strobe(16'h0020, 32'h3333_0000);
        chk("ovf5_setwins", 32'(bus.ovf), 32'h0020);
        tick;
        bus.ovf_clr = 1'b0;
        chk("ovf5_clr", 32'(bus.ovf), 32'd0);
        bus.en = 1'b1;
        tick;
        chk("ovf5_wen",   32'(bus.rf_wen), 32'h0020);
        chk("ovf5_wdata", bus.rf_wdata, 32'h1111_0005);
        chk("ovf5_cnt",   32'(bus.wr_cnt), 32'd1);
        tick;
        chk("ovf5_idle",  32'(bus.busy), 32'd0);

        // Commit on chain 2 with a word pending, strobe in the same cycle.
        do_reset;
        bus.en = 1'b0;
        bus.dft_op_commit = 16'h0004;
        strobe(16'h0004, 32'h2222_0000);
        tick;
        tick;
        chk("c2_wait_ack", 32'(bus.dft_commit_ack), 32'd0);
        bus.en  = 1'b1;
        wen_at  = -1;
        ack_at  = -1;
        ack_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            tick;
            if (bus.rf_wen[2]) wen_at = c;
            if (bus.dft_commit_ack[2]) begin
                ack_cnt++;
                if (ack_at < 0) ack_at = c;
            end
        end
        chk("c2_wen_seen", 32'(wen_at), 32'd0);
        chk("c2_wdata",    bus.rf_wdata, 32'h2222_0002);
        chk("c2_ack_at",   32'(ack_at), 32'd2);
        chk("c2_ack_cnt",  32'(ack_cnt), 32'd1);
        bus.dft_op_commit = '0;
        tick;
        tick;
        bus.dft_op_commit = 16'h0004;
        tick;
        tick;
        chk("c2_reack", 32'(bus.dft_commit_ack), 32'h0004);
        tick;
        chk("c2_reack_off", 32'(bus.dft_commit_ack), 32'd0);
        bus.dft_op_commit = '0;
        tick;

        // Commit withdrawn while draining produces no ack.
        bus.en = 1'b0;
        bus.dft_op_commit = 16'h0004;
        strobe(16'h0004, 32'h4444_0000);
        bus.dft_op_commit = '0;
        tick;
        bus.en  = 1'b1;
        ack_cnt = 0;
        for (int c = 0; c < 6; c++) begin
            tick;
            if (bus.dft_commit_ack[2]) ack_cnt++;
        end
        chk("c2_drop_noack", 32'(ack_cnt), 32'd0);

        // Mid-operation reset with four pending words.
        do_reset;
        bus.en = 1'b1;
        strobe(16'h0040, 32'h6666_0000);
        tick;
        bus.en = 1'b0;
        strobe(16'h0292, 32'h7777_0000);
        strobe(16'h0010, 32'h8888_0000);
        chk("mr_busy", 32'(bus.busy), 32'd1);
        chk("mr_ovf",  32'(bus.ovf), 32'h0010);
        bus.dft_op_commit = 16'h0080;
        tick;
        #2;
        reset = 1'b0;
        #1;
        chk("mr_wen",   32'(bus.rf_wen), 32'd0);
        chk("mr_wdata", bus.rf_wdata, 32'd0);
        chk("mr_busy0", 32'(bus.busy), 32'd0);
        chk("mr_ovf0",  32'(bus.ovf), 32'd0);
        chk("mr_cnt0",  32'(bus.wr_cnt), 32'd0);
        bus.dft_op_commit = '0;
        tick;
        reset  = 1'b1;
        bus.en = 1'b1;
        wen_cnt = 0;
        ack_cnt = 0;
        for (int c = 0; c < 4; c++) begin
            tick;
            if (bus.rf_wen != '0) wen_cnt++;
            if (bus.dft_commit_ack != '0) ack_cnt++;
        end
        chk("mr_nowen", 32'(wen_cnt), 32'd0);
        chk("mr_noack", 32'(ack_cnt), 32'd0);
        strobe(16'h0408, 32'h9999_0000);
        tick;
        chk("mr_first",  32'(bus.rf_wen), 32'h0008);
        tick;
        chk("mr_second", 32'(bus.rf_wen), 32'h0400);

        // Write counter wrap via back-to-back words on chain 0.
        do_reset;
        bus.en = 1'b1;
        bus.dft_output_strobe = 16'h0001;
        for (int i = 0; i < 65535; i++) begin
            bus.dft_output_data[31:0] = 32'(i);
            tick;
        end
        bus.dft_output_strobe = '0;
        wait_idle("wrap_idle1");
        chk("wrap_ffff",  32'(bus.wr_cnt), 32'h0000_FFFF);
        chk("wrap_wdata", bus.rf_wdata, 32'h0000_FFFE);
        chk("wrap_ovf",   32'(bus.ovf), 32'd0);
        strobe(16'h0001, 32'hBEEF_0000);
        wait_idle("wrap_idle2");
        chk("wrap_zero",   32'(bus.wr_cnt), 32'd0);
        chk("wrap_wdata2", bus.rf_wdata, 32'hBEEF_0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/dft_readout_arbiter.md
DFT_READOUT_ARBITER -- requirements
Module: dft_readout_arbiter

Interface
REQ-001 SHALL have parameter p_sc_nbr, default 16, number of scan chains arbitrated (N, 2..16).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port en  input  1  grant enable; capture continues when low.
REQ-005 SHALL have port dft_output_data  input  32*N  chain i word on bits [32i+31:32i].
REQ-006 SHALL have port dft_output_strobe  input  N  one-cycle valid per chain word.
REQ-007 SHALL have port dft_op_commit  input  N  level; chain i finished its operation.
REQ-008 SHALL have port dft_commit_ack  output  N  one-cycle acknowledge per commit.
REQ-009 SHALL have port rf_wen  output  N  one-hot write strobe to the chain i readout register.
REQ-010 SHALL have port rf_wdata  output  32  write data accompanying rf_wen.
REQ-011 SHALL have port wr_cnt  output  16  total rf_wen pulses issued, wrapping.
REQ-012 SHALL have port ovf  output  N  sticky per-chain overflow flag.
REQ-013 SHALL have port ovf_clr  input  1  one-cycle clear of all ovf bits.
REQ-014 SHALL have port busy  output  1  any pending word or rf_wen in flight.

Function
REQ-015 SHALL hold per chain a one-word buffer buf[i] and pending bit pend[i].
REQ-016 SHALL capture on strobe[i] with pend[i]=0: next edge buf[i]<=data, pend[i]<=1.
REQ-017 SHALL accept strobe[i] with pend[i]=1 only if chain i is granted that cycle (buffer refilled, pend stays 1).
REQ-018 SHALL otherwise drop that word, keep buf[i] unchanged, set ovf[i].
REQ-019 SHALL, when en=1 and any pend set, grant exactly one chain per cycle: first pending index at or after ptr, cyclically modulo N.
REQ-020 SHALL, on grant of i, clear pend[i] (unless REQ-017), set ptr<=(i+1) mod N; no grant leaves ptr unchanged.
REQ-021 SHALL register outputs: cycle after grant, rf_wen = one-hot i for one cycle, rf_wdata = granted buf[i]; else rf_wen=0, rf_wdata holds last value.
REQ-022 SHALL give minimum latency 2 cycles strobe-to-rf_wen (strobe cycle t, rf_wen high cycle t+2).
REQ-023 SHALL increment wr_cnt by 1 per rf_wen pulse; 16'hFFFF wraps to 0.
REQ-024 SHALL run per-chain commit FSM: IDLE -> DRAIN on commit[i]=1.
REQ-025 SHALL transition DRAIN -> ACK when pend[i]=0 and rf_wen[i]=0 and no strobe[i] that cycle.
REQ-026 SHALL pulse dft_commit_ack[i] for exactly the one cycle in ACK, then go to DONE.
REQ-027 SHALL transition DONE -> IDLE when commit[i]=0; commit dropping in DRAIN returns to IDLE with no ack.
REQ-028 SHALL treat strobe and commit in the same cycle as: word captured and written before ack.
REQ-029 SHALL clear all ovf on ovf_clr; a same-cycle overflow set wins over clear for that bit.
REQ-030 SHALL drive busy = |pend OR |rf_wen.
REQ-031 SHALL, with en=0, issue no grants; pending words and commit FSMs in DRAIN wait.

Reset
REQ-032 SHALL on reset=0 asynchronously clear pend, buf, ptr, ovf, wr_cnt, rf_wen, rf_wdata, dft_commit_ack, busy to 0 and all FSMs to IDLE.
REQ-033 SHALL discard in-flight words and unacked commits on mid-operation reset; first grant after release starts at chain 0.

Verification
REQ-034 SHALL cover: single strobe chain 3 data 32'hA5A5_0003 at cycle t -> rf_wen=16'h0008, rf_wdata=32'hA5A5_0003 at t+2, wr_cnt=1.
REQ-035 SHALL cover: all 16 strobes same cycle after reset -> rf_wen chains 0,1,...,15 on 16 consecutive cycles, busy low after, wr_cnt=16.
REQ-036 SHALL cover: chain 5 strobed twice back-to-back with en=0 -> second word dropped, ovf[5]=1, first word written once en=1.
REQ-037 SHALL cover: commit[2] with pend[2]=1 -> ack[2] one cycle only after rf_wen[2] pulse; holding commit high gives no second ack.
REQ-038 SHALL cover: reset asserted with 4 pending words -> outputs 0 immediately, no rf_wen after release, ptr restarts at 0.
REQ-039 SHALL cover: wr_cnt preset to 16'hFFFF via 65535 writes, one more write -> wr_cnt=0.
